mem_read_cmd_arbiter: RTL and testbench

MEM_READ_CMD_ARBITER -- requirements
Module: mem_read_cmd_arbiter

---
 rtl/mem_read_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_read_cmd_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_cmd_arbiter.sv
// Two-source read command arbiter with order FIFO routing read data/status back to the issuing port.
// Cmd: 1-cycle registered stage, stalls on m_cmd_ready or full order FIFO; data/sts: 0-cycle pass-through. Macro: MEM_ARB_STRICT_PRIO_EN.
module mem_read_cmd_arbiter #(
  parameter int ORDER_DEPTH = 16,
  parameter int DATA_WIDTH  = 512
) (
  input  logic                    user_clk,
  input  logic                    user_areset,
  input  logic                    s0_cmd_valid,
  output logic                    s0_cmd_ready,
  input  logic [63:0]             s0_cmd_address,
  input  logic [31:0]             s0_cmd_length,
  input  logic                    s1_cmd_valid,
  output logic                    s1_cmd_ready,
  input  logic [63:0]             s1_cmd_address,
  input  logic [31:0]             s1_cmd_length,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [63:0]             m_cmd_address,
  output logic [31:0]             m_cmd_length,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_data_data,
  input  logic [DATA_WIDTH/8-1:0] s_data_keep,
  input  logic                    s_data_last,
  output logic                    m0_data_valid,
  input  logic                    m0_data_ready,
  output logic [DATA_WIDTH-1:0]   m0_data_data,
  output logic [DATA_WIDTH/8-1:0] m0_data_keep,
  output logic                    m0_data_last,
  output logic                    m1_data_valid,
  input  logic                    m1_data_ready,
  output logic [DATA_WIDTH-1:0]   m1_data_data,
  output logic [DATA_WIDTH/8-1:0] m1_data_keep,
  output logic                    m1_data_last,
  input  logic                    s_sts_valid,
  output logic                    s_sts_ready,
  input  logic [7:0]              s_sts_data,
  output logic                    m0_sts_valid,
  input  logic                    m0_sts_ready,
  output logic [7:0]              m0_sts_data,
  output logic                    m1_sts_valid,
  input  logic                    m1_sts_ready,
  output logic [7:0]              m1_sts_data
);

  localparam int AW = $clog2(ORDER_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(ORDER_DEPTH);

  logic                   cmd_vld_q, cmd_vld_d;
  logic [63:0]            cmd_addr_q, cmd_addr_d;
  logic [31:0]            cmd_len_q, cmd_len_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            dat_ptr_q, dat_ptr_d;
  logic [AW:0]            sts_ptr_q, sts_ptr_d;
  logic [ORDER_DEPTH-1:0] port_q, port_d;
`ifndef MEM_ARB_STRICT_PRIO_EN
  logic                   last_grant_q, last_grant_d;
`endif

  logic        full, can_load, grant1, push;
  logic        dat_pend, dat_port, sts_pend, sts_port;
  logic [AW:0] occ;

  assign occ      = wr_ptr_q - sts_ptr_q;
  assign full     = (occ == FULL_OCC);
  assign can_load = ~user_areset & (~cmd_vld_q | m_cmd_ready) & ~full;

`ifdef MEM_ARB_STRICT_PRIO_EN
  assign grant1 = s1_cmd_valid & ~s0_cmd_valid;
`else
  // Port 1 wins a tie only if port 0 took the previous grant.
  assign grant1 = s1_cmd_valid & (~s0_cmd_valid | ~last_grant_q);
`endif

  assign s0_cmd_ready = can_load & s0_cmd_valid & ~grant1;
  assign s1_cmd_ready = can_load & grant1;
  assign push         = (s0_cmd_valid & s0_cmd_ready) | (s1_cmd_valid & s1_cmd_ready);

  assign m_cmd_valid   = cmd_vld_q;
  assign m_cmd_address = cmd_addr_q;
  assign m_cmd_length  = cmd_len_q;

  assign dat_pend      = (dat_ptr_q != wr_ptr_q);
  assign dat_port      = port_q[dat_ptr_q[AW-1:0]];
  assign m0_data_valid = s_data_valid & dat_pend & ~dat_port;
  assign m1_data_valid = s_data_valid & dat_pend & dat_port;
  assign s_data_ready  = dat_pend & (dat_port ? m1_data_ready : m0_data_ready);
  assign m0_data_data  = s_data_data;
  assign m0_data_keep  = s_data_keep;
  assign m0_data_last  = s_data_last;
  assign m1_data_data  = s_data_data;
  assign m1_data_keep  = s_data_keep;
  assign m1_data_last  = s_data_last;

  assign sts_pend      = (sts_ptr_q != wr_ptr_q);
  assign sts_port      = port_q[sts_ptr_q[AW-1:0]];
  assign m0_sts_valid  = s_sts_valid & sts_pend & ~sts_port;
  assign m1_sts_valid  = s_sts_valid & sts_pend & sts_port;
  assign s_sts_ready   = sts_pend & (sts_port ? m1_sts_ready : m0_sts_ready);
  assign m0_sts_data   = s_sts_data;
  assign m1_sts_data   = s_sts_data;

  always_comb begin
    cmd_vld_d  = cmd_vld_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    wr_ptr_d   = wr_ptr_q;
    dat_ptr_d  = dat_ptr_q;
    sts_ptr_d  = sts_ptr_q;
    port_d     = port_q;
`ifndef MEM_ARB_STRICT_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    if (cmd_vld_q && m_cmd_ready) cmd_vld_d = 1'b0;
    if (push) begin
      cmd_vld_d  = 1'b1;
      cmd_addr_d = grant1 ? s1_cmd_address : s0_cmd_address;
      cmd_len_d  = grant1 ? s1_cmd_length : s0_cmd_length;
      port_d[wr_ptr_q[AW-1:0]] = grant1;
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
`ifndef MEM_ARB_STRICT_PRIO_EN
      last_grant_d = grant1;
`endif
    end
    if (s_data_valid && s_data_ready && s_data_last) dat_ptr_d = dat_ptr_q + PTR_ONE;
    if (s_sts_valid && s_sts_ready) sts_ptr_d = sts_ptr_q + PTR_ONE;
  end

  always_ff @(posedge user_clk or posedge user_areset) begin
    if (user_areset) begin
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      wr_ptr_q   <= '0;
      dat_ptr_q  <= '0;
      sts_ptr_q  <= '0;
      port_q     <= '0;
`ifndef MEM_ARB_STRICT_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      cmd_vld_q  <= cmd_vld_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      wr_ptr_q   <= wr_ptr_d;
      dat_ptr_q  <= dat_ptr_d;
      sts_ptr_q  <= sts_ptr_d;
      port_q     <= port_d;
`ifndef MEM_ARB_STRICT_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_read_cmd_arbiter.sv
// Directed bench for mem_read_cmd_arbiter: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mem_read_cmd_arbiter;
  localparam int DW = 512;
  localparam int KW = DW/8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          user_clk = 1'b0;
  logic          user_areset = 1'b1;
  logic          s0_cmd_valid = 0, s1_cmd_valid = 0, m_cmd_ready = 1;
  logic          s0_cmd_ready, s1_cmd_ready, m_cmd_valid;
  logic [63:0]   s0_cmd_address = 0, s1_cmd_address = 0, m_cmd_address;
  logic [31:0]   s0_cmd_length = 0, s1_cmd_length = 0, m_cmd_length;
  logic          s_data_valid = 0, s_data_last = 0, s_data_ready;
  logic [DW-1:0] s_data_data = '0;
  logic [KW-1:0] s_data_keep = '0;
  logic          m0_data_valid, m0_data_last, m1_data_valid, m1_data_last;
  logic          m0_data_ready = 1, m1_data_ready = 1;
  logic [DW-1:0] m0_data_data, m1_data_data;
  logic [KW-1:0] m0_data_keep, m1_data_keep;
  logic          s_sts_valid = 0, s_sts_ready;
  logic [7:0]    s_sts_data = 0, m0_sts_data, m1_sts_data;
  logic          m0_sts_valid, m1_sts_valid, m0_sts_ready = 1, m1_sts_ready = 1;

  int total = 0;
  int bad = 0;

  logic [95:0] exp_cmd[$];
  beat_t       exp_d0[$], exp_d1[$];
  logic [7:0]  exp_s0[$], exp_s1[$];

  mem_read_cmd_arbiter #(.ORDER_DEPTH(16), .DATA_WIDTH(DW)) dut (
    .user_clk(user_clk), .user_areset(user_areset),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
    .s0_cmd_address(s0_cmd_address), .s0_cmd_length(s0_cmd_length),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
    .s1_cmd_address(s1_cmd_address), .s1_cmd_length(s1_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m0_data_valid(m0_data_valid), .m0_data_ready(m0_data_ready), .m0_data_data(m0_data_data),
    .m0_data_keep(m0_data_keep), .m0_data_last(m0_data_last),
    .m1_data_valid(m1_data_valid), .m1_data_ready(m1_data_ready), .m1_data_data(m1_data_data),
    .m1_data_keep(m1_data_keep), .m1_data_last(m1_data_last),
    .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
    .m0_sts_valid(m0_sts_valid), .m0_sts_ready(m0_sts_ready), .m0_sts_data(m0_sts_data),
    .m1_sts_valid(m1_sts_valid), .m1_sts_ready(m1_sts_ready), .m1_sts_data(m1_sts_data)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [639:0] got);
    total++;
    bad++;
    $display("FAIL %s unexpected output got=%0h", nm, got);
  endtask

  // Scoreboard monitor: every output handshake must match the head of its queue.
  always @(negedge user_clk) begin
    if (!user_areset) begin
      if (m_cmd_valid && m_cmd_ready) begin
        if (exp_cmd.size() == 0) unexp("m_cmd", {m_cmd_address, m_cmd_length});
        else chk("m_cmd", {m_cmd_address, m_cmd_length}, exp_cmd.pop_front());
      end
      if (m0_data_valid && m0_data_ready) begin
        if (exp_d0.size() == 0) unexp("m0_data", {m0_data_data, m0_data_keep, m0_data_last});
        else chk("m0_data", {m0_data_data, m0_data_keep, m0_data_last}, exp_d0.pop_front());
      end
      if (m1_data_valid && m1_data_ready) begin
        if (exp_d1.size() == 0) unexp("m1_data", {m1_data_data, m1_data_keep, m1_data_last});
        else chk("m1_data", {m1_data_data, m1_data_keep, m1_data_last}, exp_d1.pop_front());
      end
      if (m0_sts_valid && m0_sts_ready) begin
        if (exp_s0.size() == 0) unexp("m0_sts", m0_sts_data);
        else chk("m0_sts", m0_sts_data, exp_s0.pop_front());
      end
      if (m1_sts_valid && m1_sts_ready) begin
        if (exp_s1.size() == 0) unexp("m1_sts", m1_sts_data);
        else chk("m1_sts", m1_sts_data, exp_s1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send_cmd(input int p, input logic [63:0] a, input logic [31:0] l);
    bit ok = 0;
    exp_cmd.push_back({a, l});
    if (p == 0) begin s0_cmd_valid = 1; s0_cmd_address = a; s0_cmd_length = l; end
    else begin s1_cmd_valid = 1; s1_cmd_address = a; s1_cmd_length = l; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge user_clk);
      ok = (p == 0) ? s0_cmd_ready : s1_cmd_ready;
      step();
    end
    s0_cmd_valid = 0;
    s1_cmd_valid = 0;
    if (!ok) unexp("cmd_accept_timeout", a);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input int p);
    bit ok = 0;
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    if (p == 0) exp_d0.push_back(b); else exp_d1.push_back(b);
    s_data_valid = 1; s_data_data = d; s_data_keep = k; s_data_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge user_clk);
      ok = s_data_ready;
      step();
    end
    s_data_valid = 0;
    if (!ok) unexp("data_accept_timeout", d);
  endtask

  task automatic send_sts(input logic [7:0] s, input int p);
    bit ok = 0;
    if (p == 0) exp_s0.push_back(s); else exp_s1.push_back(s);
    s_sts_valid = 1; s_sts_data = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge user_clk);
      ok = s_sts_ready;
      step();
    end
    s_sts_valid = 0;
    if (!ok) unexp("sts_accept_timeout", s);
  endtask

  task automatic do_reset();
    chk("queues_drained", exp_cmd.size() + exp_d0.size() + exp_d1.size() + exp_s0.size() + exp_s1.size(), 0);
    s0_cmd_valid = 0; s1_cmd_valid = 0; s_data_valid = 0; s_sts_valid = 0;
    m_cmd_ready = 1;
    user_areset = 1;
    step();
    step();
    user_areset = 0;
  endtask

  initial begin
    int n;
    int exp_p;
    logic [KW-1:0] kall;
    kall = '1;

    // Reset state, with inputs asserted to prove outputs are gated.
    s0_cmd_valid = 1; s_data_valid = 1; s_sts_valid = 1;
    #2;
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_addr_len", {m_cmd_address, m_cmd_length}, 0);
    chk("rst_cmd_readies", {s1_cmd_ready, s0_cmd_ready}, 0);
    chk("rst_data_sts", {s_data_ready, m0_data_valid, m1_data_valid, s_sts_ready, m0_sts_valid, m1_sts_valid}, 0);
    step();
    do_reset();

    // Round-robin under continuous requests.
`ifdef MEM_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 6; i++) exp_cmd.push_back({64'h100, 32'd1});
`else
    for (int i = 0; i < 6; i++) exp_cmd.push_back((i % 2 == 0) ? {64'h100, 32'd1} : {64'h200, 32'd2});
`endif
    s0_cmd_valid = 1; s0_cmd_address = 64'h100; s0_cmd_length = 1;
    s1_cmd_valid = 1; s1_cmd_address = 64'h200; s1_cmd_length = 2;
    n = 0;
    for (int i = 0; i < 20 && n < 6; i++) begin
      @(negedge user_clk);
`ifdef MEM_ARB_STRICT_PRIO_EN
      exp_p = 0;
`else
      exp_p = n % 2;
`endif
      chk("rr_grant", {s1_cmd_ready, s0_cmd_ready}, (exp_p == 1) ? 2'b10 : 2'b01);
      if (s0_cmd_ready || s1_cmd_ready) n++;
      step();
    end
    s0_cmd_valid = 0; s1_cmd_valid = 0;
    chk("rr_count", n, 6);
    step(); step();
    do_reset();

    // Two commands, three beats, two statuses routed back by issue order.
    send_cmd(0, 64'h1000, 32'd128);
    send_cmd(1, 64'h2000, 32'd64);
    send_beat({16{32'hA1A1_0001}}, kall, 1'b0, 0);
    send_beat({16{32'hA2A2_0002}}, kall, 1'b1, 0);
    send_beat({16{32'hB3B3_0003}}, 64'h0000_0000_FFFF_FFFF, 1'b1, 1);
    send_sts(8'h80, 0);
    send_sts(8'h80, 1);
    step(); step();
    do_reset();

    // Output stage holds while m_cmd_ready is low.
    m_cmd_ready = 0;
    exp_cmd.push_back({64'h3000, 32'd8});
    exp_cmd.push_back({64'h3001, 32'd8});
    s0_cmd_valid = 1; s0_cmd_address = 64'h3000; s0_cmd_length = 8;
    @(negedge user_clk);
    chk("stall_first_load_rdy", s0_cmd_ready, 1);
    step();
    s0_cmd_address = 64'h3001;
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      chk("stall_hold", {m_cmd_valid, m_cmd_address, s0_cmd_ready}, {1'b1, 64'h3000, 1'b0});
      step();
    end
    m_cmd_ready = 1;
    @(negedge user_clk);
    chk("stall_release_rdy", s0_cmd_ready, 1);
    step();
    s0_cmd_valid = 0;
    step(); step();
    do_reset();

    // Order FIFO full after 16 outstanding; one status frees one slot.
    for (int i = 0; i < 16; i++) send_cmd(0, 64'h4000 + 64'(i), 32'd4);
    s0_cmd_valid = 1; s0_cmd_address = 64'h4100; s0_cmd_length = 4;
    s1_cmd_valid = 1; s1_cmd_address = 64'h5000; s1_cmd_length = 5;
    s_sts_valid = 1; s_sts_data = 8'h80;
    exp_s0.push_back(8'h80);
    @(negedge user_clk);
    chk("full_readies_low", {s1_cmd_ready, s0_cmd_ready}, 2'b00);
    chk("full_sts_ready", s_sts_ready, 1);
    step();
    s_sts_valid = 0;
    @(negedge user_clk);
`ifdef MEM_ARB_STRICT_PRIO_EN
    chk("after_pop_one_grant", {s1_cmd_ready, s0_cmd_ready}, 2'b01);
    exp_cmd.push_back({64'h4100, 32'd4});
`else
    chk("after_pop_one_grant", {s1_cmd_ready, s0_cmd_ready}, 2'b10);
    exp_cmd.push_back({64'h5000, 32'd5});
`endif
    step();
    @(negedge user_clk);
    chk("full_again", {s1_cmd_ready, s0_cmd_ready}, 2'b00);
    step();
    s0_cmd_valid = 0; s1_cmd_valid = 0;
    step(); step();
    do_reset();

    // Data and status presented with nothing outstanding.
    s_data_valid = 1; s_sts_valid = 1;
    @(negedge user_clk);
    chk("empty_data", {s_data_ready, m0_data_valid, m1_data_valid}, 3'b000);
    chk("empty_sts", {s_sts_ready, m0_sts_valid, m1_sts_valid}, 3'b000);
    step();
    s_data_valid = 0; s_sts_valid = 0;
    step();
    do_reset();

    // Reset mid-burst with three outstanding commands.
    send_cmd(0, 64'h6000, 32'd2);
    send_cmd(1, 64'h6100, 32'd2);
    send_cmd(0, 64'h6200, 32'd2);
    send_beat({16{32'hC0C0_0006}}, kall, 1'b0, 0);
    step(); step();
    chk("pre_reset_drained", exp_cmd.size() + exp_d0.size(), 0);
    s0_cmd_valid = 1; s0_cmd_address = 64'h7000; s0_cmd_length = 7;
    s1_cmd_valid = 1; s1_cmd_address = 64'h7100; s1_cmd_length = 7;
    s_data_valid = 1; s_data_last = 1;
    user_areset = 1;
    #2;
    chk("mid_rst_outputs", {m_cmd_valid, s0_cmd_ready, s1_cmd_ready, s_data_ready, m0_data_valid, m1_data_valid}, 6'b0);
    step();
    user_areset = 0;
    exp_cmd.push_back({64'h7000, 32'd7});
    @(negedge user_clk);
    chk("post_rst_no_pending", {s_data_ready, m0_data_valid, m1_data_valid}, 3'b000);
    chk("post_rst_tie_port0", {s1_cmd_ready, s0_cmd_ready}, 2'b01);
    step();
    s0_cmd_valid = 0; s1_cmd_valid = 0; s_data_valid = 0;
    step(); step();
    chk("final_queues_drained", exp_cmd.size() + exp_d0.size() + exp_d1.size() + exp_s0.size() + exp_s1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
